soc_vga_scanout: RTL and testbench
==================================

SOC_VGA_SCANOUT -- requirements
Module: soc_vga_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33: porch and sync lengths in pixel clocks and lines.
REQ-003 SHALL have parameter FB_WIDTH, default 320, framebuffer pixels per row; each stored pixel covers a 2x2 screen block.
REQ-004 SHALL have parameter FB_BASE_1, default 76800, byte address of buffer 1; buffer 0 is at byte address 0.
REQ-005 SHALL have parameter ADDR_WIDTH_B, default 32, framebuffer read-address width.
REQ-006 SHALL have port vga_clk  input  1  pixel clock; the only clock.
REQ-007 SHALL have port res_n  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port enable  input  1  scan-out enable; level, sampled once per frame.
REQ-009 SHALL have port frame_sel  input  1  requested display buffer; asynchronous to vga_clk.
REQ-010 SHALL have port word_addr_b  output  ADDR_WIDTH_B  byte address to the framebuffer read port.
REQ-011 SHALL have port read_data_b  input  8  RGB332 pixel returned one vga_clk after word_addr_b.
REQ-012 SHALL have ports vga_r, vga_g, vga_b  output  4 each  pixel colour.
REQ-013 SHALL have ports hsync, vsync  output  1 each  active-low sync pulses.
REQ-014 SHALL have port frame_shown  output  1  buffer index currently being displayed.
REQ-015 SHALL have port vblank_pulse  output  1  one-cycle strobe at start of vertical blank.

Function
REQ-016 SHALL keep h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), incrementing every cycle and wrapping to 0.
REQ-017 SHALL increment v_cnt 0..V_TOTAL-1 (525) when h_cnt wraps, and wrap v_cnt to 0 after V_TOTAL-1.
REQ-018 SHALL define stage-0 display enable de0 = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-019 SHALL define hs0 low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and vs0 low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-020 SHALL drive word_addr_b combinationally from registered state as base + (v_cnt>>1)*FB_WIDTH + (h_cnt>>1), zero-extended to ADDR_WIDTH_B.
REQ-021 SHALL hold word_addr_b at base when de0 is low.
REQ-022 SHALL delay de0, hs0 and vs0 one cycle to align with read_data_b, then register all VGA outputs, for a fixed 2-cycle latency from counter state to outputs.
REQ-023 SHALL expand pixel p as r={p[7:5],p[7]}, g={p[4:2],p[4]}, b={p[1:0],p[1:0]}.
REQ-024 SHALL output rgb = 0 when delayed de is low or when the frame-latched enable is low; sync pulses SHALL continue regardless of enable.
REQ-025 SHALL pass frame_sel through a 2-flop synchronizer.
REQ-026 SHALL latch the synchronized frame_sel into frame_shown, and enable into the internal enable register, only in the cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1; a frame never switches mid-frame.
REQ-027 SHALL set base = 0 when frame_shown=0 and base = FB_BASE_1 when frame_shown=1.
REQ-028 SHALL assert vblank_pulse for exactly one cycle, registered, when h_cnt=0 and v_cnt=V_ACTIVE.
REQ-029 SHALL use an FSM over line states ACTIVE, FRONT, SYNC, BACK for the vertical axis, with transitions at the REQ-019 boundaries; h_cnt alone decodes the horizontal axis.

Reset
REQ-030 SHALL, on res_n low, asynchronously clear h_cnt, v_cnt, the synchronizer, frame_shown, the enable register, vblank_pulse and vga_r/g/b; hsync and vsync SHALL reset high, and the vertical FSM SHALL reset to ACTIVE.
REQ-031 SHALL start counting on the first vga_clk edge after res_n deasserts, with the first displayed frame using frame_shown=0 and enable=0.
REQ-032 SHALL abandon the current frame when reset asserts mid-frame, with no partial-state carry-over after release.

Structure
REQ-033 SHALL place the default VGA timing constants, H_TOTAL/V_TOTAL and the vertical-state enum typedef in the shared soc package.
REQ-034 SHALL implement the 2-flop synchronizer as sub-module soc_sync_2ff; all other logic is inline.

Verification
REQ-035 Release reset, enable=1, frame_sel=0 -> hsync period 800 cycles, low for 96; vsync period 420000 cycles, low for 1600.
REQ-036 read_data_b=8'hE0 constant -> during active video vga_r=4'hF, vga_g=0, vga_b=0, two cycles after de0 rises; 0 in blank.
REQ-037 h_cnt=3, v_cnt=5 -> word_addr_b = 2*320+1 = 641; with frame_shown=1 -> 77441.
REQ-038 Toggle frame_sel mid-frame -> frame_shown changes only at the frame boundary after at least 2 sync cycles; the address base switches on the next frame's first pixel.
REQ-039 enable=0 -> rgb stays 0 while sync continues; vblank_pulse fires once per frame at v_cnt=480, h_cnt=0.
REQ-040 Assert res_n low at v_cnt=200 -> all outputs reach reset values immediately; after release, h_cnt=v_cnt=0.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared SoC video constants: default VGA 640x480@60 timing and the vertical line-state type.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package soc_pkg;

    // Default horizontal timing, in pixel clocks
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    // Default vertical timing, in lines
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Framebuffer layout: 320-wide half-resolution buffer, second buffer right after the first
    localparam int DEF_FB_WIDTH     = 320;
    localparam int DEF_FB_BASE_1    = 76800;
    localparam int DEF_ADDR_WIDTH_B = 32;

    // Counter width, wide enough for any sane raster total
    localparam int CNT_W = 12;

    // Vertical line state
    typedef enum logic [1:0] {
        V_ST_ACTIVE = 2'd0,
        V_ST_FRONT  = 2'd1,
        V_ST_SYNC   = 2'd2,
        V_ST_BACK   = 2'd3
    } v_state_t;

endpackage

// File: rtl/soc_sync_2ff.sv
// Two-flop synchronizer bringing a single level signal into the local clock domain.
// Latency: 2 clocks from a settled input to o_q.
// Backpressure: none; free-running, samples every clock.
module soc_sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability-resolving flop chain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/soc_vga_scanout.sv
// VGA raster scan-out of a double-buffered, 2x2-upscaled RGB332 framebuffer.
// Latency: 2 vga_clk from counter state to registered rgb/hsync/vsync; address is combinational.
// Backpressure: none; the read port must return data one clock after word_addr_b, every clock.
module soc_vga_scanout
    import soc_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter int FB_WIDTH     = DEF_FB_WIDTH,
    parameter int FB_BASE_1    = DEF_FB_BASE_1,
    parameter int ADDR_WIDTH_B = DEF_ADDR_WIDTH_B
) (
    input  logic                    vga_clk,
    input  logic                    res_n,
    input  logic                    enable,
    input  logic                    frame_sel,
    output logic [ADDR_WIDTH_B-1:0] word_addr_b,
    input  logic [7:0]              read_data_b,
    output logic [3:0]              vga_r,
    output logic [3:0]              vga_g,
    output logic [3:0]              vga_b,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    frame_shown,
    output logic                    vblank_pulse
);

    localparam int HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;

    logic [CNT_W-1:0]        r_h_cnt;
    logic [CNT_W-1:0]        r_v_cnt;
    v_state_t                r_v_state;
    v_state_t                w_v_state_nxt;
    logic                    w_v_act;
    logic                    w_vs0;
    logic                    w_hs0;
    logic                    w_de0;
    logic                    w_h_last;
    logic                    w_v_last;
    logic                    w_frame_end;
    logic [CNT_W-1:0]        w_v_cnt_nxt;
    logic                    w_sel_sync;
    logic                    r_frame_shown;
    logic                    r_en;
    logic                    r_vblank;
    logic                    r_de1;
    logic                    r_hs1;
    logic                    r_vs1;
    logic [3:0]              r_vga_r;
    logic [3:0]              r_vga_g;
    logic [3:0]              r_vga_b;
    logic                    r_hsync;
    logic                    r_vsync;
    logic [ADDR_WIDTH_B-1:0] w_base;
    logic [ADDR_WIDTH_B-1:0] w_pix_off;

    assign w_h_last    = (r_h_cnt == CNT_W'(HT - 1));
    assign w_v_last    = (r_v_cnt == CNT_W'(VT - 1));
    assign w_frame_end = w_h_last && w_v_last;
    assign w_v_cnt_nxt = w_v_last ? '0 : r_v_cnt + CNT_W'(1);

    // Raster position: h wraps every line, v advances on each h wrap
    always_ff @(posedge vga_clk or negedge res_n) begin
        if (!res_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_cnt_nxt;
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    // Vertical line-state register
    always_ff @(posedge vga_clk or negedge res_n) begin
        if (!res_n) begin
            r_v_state <= V_ST_ACTIVE;
        end else begin
            r_v_state <= w_v_state_nxt;
        end
    end

    // Vertical state moves only at line wrap, keyed on the line about to start
    always_comb begin
        w_v_state_nxt = r_v_state;
        w_v_act       = (r_v_state == V_ST_ACTIVE);
        w_vs0         = (r_v_state != V_ST_SYNC);
        if (w_h_last) begin
            case (r_v_state)
                V_ST_ACTIVE: if (w_v_cnt_nxt == CNT_W'(V_ACTIVE)) w_v_state_nxt = V_ST_FRONT;
                V_ST_FRONT:  if (w_v_cnt_nxt == CNT_W'(VS_BEG))   w_v_state_nxt = V_ST_SYNC;
                V_ST_SYNC:   if (w_v_cnt_nxt == CNT_W'(VS_END))   w_v_state_nxt = V_ST_BACK;
                V_ST_BACK:   if (w_v_cnt_nxt == '0)               w_v_state_nxt = V_ST_ACTIVE;
                default:                                          w_v_state_nxt = V_ST_ACTIVE;
            endcase
        end
    end

    assign w_de0 = (r_h_cnt < CNT_W'(H_ACTIVE)) && w_v_act;
    assign w_hs0 = !((r_h_cnt >= CNT_W'(HS_BEG)) && (r_h_cnt < CNT_W'(HS_END)));

    // Each stored pixel spans 2x2 screen pixels, so both counters drop their LSB
    assign w_base      = r_frame_shown ? ADDR_WIDTH_B'(FB_BASE_1) : '0;
    assign w_pix_off   = ADDR_WIDTH_B'(r_v_cnt >> 1) * ADDR_WIDTH_B'(FB_WIDTH)
                       + ADDR_WIDTH_B'(r_h_cnt >> 1);
    assign word_addr_b = w_de0 ? (w_base + w_pix_off) : w_base;

    soc_sync_2ff u_sel_sync (
        .i_clk   (vga_clk),
        .i_rst_n (res_n),
        .i_d     (frame_sel),
        .o_q     (w_sel_sync)
    );

    // Buffer select and enable change only on the last pixel of the frame
    always_ff @(posedge vga_clk or negedge res_n) begin
        if (!res_n) begin
            r_frame_shown <= 1'b0;
            r_en          <= 1'b0;
        end else if (w_frame_end) begin
            r_frame_shown <= w_sel_sync;
            r_en          <= enable;
        end
    end

    // One-clock strobe on the first pixel of the first blank line
    always_ff @(posedge vga_clk or negedge res_n) begin
        if (!res_n) begin
            r_vblank <= 1'b0;
        end else begin
            r_vblank <= (r_h_cnt == '0) && (r_v_cnt == CNT_W'(V_ACTIVE));
        end
    end

    // Stage 1: timing delayed to line up with read_data_b
    always_ff @(posedge vga_clk or negedge res_n) begin
        if (!res_n) begin
            r_de1 <= 1'b0;
            r_hs1 <= 1'b1;
            r_vs1 <= 1'b1;
        end else begin
            r_de1 <= w_de0;
            r_hs1 <= w_hs0;
            r_vs1 <= w_vs0;
        end
    end

    // Stage 2: RGB332 widened to 4:4:4 by bit replication, blanked outside video or when disabled
    always_ff @(posedge vga_clk or negedge res_n) begin
        if (!res_n) begin
            r_vga_r <= '0;
            r_vga_g <= '0;
            r_vga_b <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_hsync <= r_hs1;
            r_vsync <= r_vs1;
            if (r_de1 && r_en) begin
                r_vga_r <= {read_data_b[7:5], read_data_b[7]};
                r_vga_g <= {read_data_b[4:2], read_data_b[4]};
                r_vga_b <= {read_data_b[1:0], read_data_b[1:0]};
            end else begin
                r_vga_r <= '0;
                r_vga_g <= '0;
                r_vga_b <= '0;
            end
        end
    end

    assign vga_r        = r_vga_r;
    assign vga_g        = r_vga_g;
    assign vga_b        = r_vga_b;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign frame_shown  = r_frame_shown;
    assign vblank_pulse = r_vblank;

endmodule

// File: tb/tb_soc_vga_scanout.sv
// Directed bench for soc_vga_scanout: 800-clock lines, 14-line frames (11200 clocks).
// Output sampled at bench cycle c reflects raster state c-2; address reflects state c.
// Free-running design, no handshake to exercise.
module tb_soc_vga_scanout;

    localparam int FR = 11200;

    logic        vga_clk = 1'b0;
    logic        res_n;
    logic        enable;
    logic        frame_sel;
    logic [31:0] word_addr_b;
    logic [7:0]  read_data_b;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        frame_shown;
    logic        vblank_pulse;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;

    soc_vga_scanout #(
        .V_ACTIVE (8),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (2)
    ) dut (
        .vga_clk      (vga_clk),
        .res_n        (res_n),
        .enable       (enable),
        .frame_sel    (frame_sel),
        .word_addr_b  (word_addr_b),
        .read_data_b  (read_data_b),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .hsync        (hsync),
        .vsync        (vsync),
        .frame_shown  (frame_shown),
        .vblank_pulse (vblank_pulse)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic goto(input int tgt);
        while (cyc < tgt) tick();
    endtask

    initial begin
        int n;
        int t_fall;
        int t_rise;
        int t_fall2;
        int nz_rgb;
        int hs_falls;
        int vs_falls;
        int vb_cnt;
        int vb_at;
        logic hs_prev;
        logic vs_prev;

        res_n       = 1'b0;
        enable      = 1'b1;
        frame_sel   = 1'b0;
        read_data_b = 8'hE0;
        repeat (3) @(posedge vga_clk);
        #1;
        check("rst_hsync",  {31'd0, hsync}, 32'd1);
        check("rst_vsync",  {31'd0, vsync}, 32'd1);
        check("rst_rgb",    {20'd0, vga_r, vga_g, vga_b}, 32'h0);
        check("rst_frame",  {31'd0, frame_shown}, 32'd0);
        check("rst_vblank", {31'd0, vblank_pulse}, 32'd0);
        check("rst_addr",   word_addr_b, 32'd0);

        @(negedge vga_clk);
        res_n = 1'b1;
        cyc   = 0;

        // Frame 0: enable register still 0 from reset
        goto(5 * 800 + 3);
        check("addr_h3_v5_buf0", word_addr_b, 32'd641);
        goto(5 * 800 + 12);
        check("f0_rgb_disabled", {20'd0, vga_r, vga_g, vga_b}, 32'h0);

        // Frame 1: enabled, buffer 0
        goto(FR + 1);
        check("f1_rgb_before_de", {20'd0, vga_r, vga_g, vga_b}, 32'h0);
        tick();
        check("f1_rgb_first_px",  {20'd0, vga_r, vga_g, vga_b}, 32'hF00);

        goto(FR + 100);
        read_data_b = 8'h5B;
        tick();
        check("expand_5B", {20'd0, vga_r, vga_g, vga_b}, 32'h4DF);
        read_data_b = 8'h25;
        tick();
        check("expand_25", {20'd0, vga_r, vga_g, vga_b}, 32'h225);
        read_data_b = 8'hE0;

        goto(FR + 641);
        check("last_active_px", {20'd0, vga_r, vga_g, vga_b}, 32'hF00);
        tick();
        check("first_blank_px", {20'd0, vga_r, vga_g, vga_b}, 32'h0);

        // hsync timing by measurement, bounded
        n = 0;
        while (hsync !== 1'b0 && n < 2000) begin tick(); n++; end
        t_fall = cyc;
        while (hsync !== 1'b1 && n < 2000) begin tick(); n++; end
        t_rise = cyc;
        while (hsync !== 1'b0 && n < 2000) begin tick(); n++; end
        t_fall2 = cyc;
        check("hsync_fall_pos", t_fall, FR + 658);
        check("hsync_low_len",  t_rise - t_fall, 32'd96);
        check("hsync_period",   t_fall2 - t_fall, 32'd800);

        // Request buffer 1 mid-frame
        goto(FR + 4000);
        frame_sel = 1'b1;

        goto(FR + 6400);
        check("f1_vblank_pre",  {31'd0, vblank_pulse}, 32'd0);
        tick();
        check("f1_vblank_hit",  {31'd0, vblank_pulse}, 32'd1);
        tick();
        check("f1_vblank_post", {31'd0, vblank_pulse}, 32'd0);

        goto(FR + 8001);
        check("f1_vs_pre",  {31'd0, vsync}, 32'd1);
        tick();
        check("f1_vs_low",  {31'd0, vsync}, 32'd0);
        goto(FR + 9601);
        check("f1_vs_last", {31'd0, vsync}, 32'd0);
        tick();
        check("f1_vs_high", {31'd0, vsync}, 32'd1);

        goto(2 * FR - 1);
        check("frame_hold_mid", {31'd0, frame_shown}, 32'd0);
        check("addr_end_f1",    word_addr_b, 32'd0);
        tick();
        check("frame_switch",   {31'd0, frame_shown}, 32'd1);
        check("addr_f2_first",  word_addr_b, 32'd76800);

        // Frame 2: buffer 1
        goto(2 * FR + 4003);
        check("addr_h3_v5_buf1", word_addr_b, 32'd77441);
        enable = 1'b0;
        goto(2 * FR + 4102);
        check("f2_rgb_en_mid", {20'd0, vga_r, vga_g, vga_b}, 32'hF00);

        goto(2 * FR + 8001);
        check("f2_vs_pre",  {31'd0, vsync}, 32'd1);
        tick();
        check("f2_vs_low",  {31'd0, vsync}, 32'd0);
        goto(2 * FR + 9601);
        check("f2_vs_last", {31'd0, vsync}, 32'd0);
        tick();
        check("f2_vs_high", {31'd0, vsync}, 32'd1);

        // Frame 3: disabled; sync and vblank keep running
        goto(3 * FR + 1);
        enable   = 1'b1;
        nz_rgb   = 0;
        hs_falls = 0;
        vs_falls = 0;
        vb_cnt   = 0;
        vb_at    = 0;
        hs_prev  = hsync;
        vs_prev  = vsync;
        for (int i = 0; i < FR; i++) begin
            tick();
            if ({vga_r, vga_g, vga_b} != 12'h0) nz_rgb++;
            if (hs_prev && !hsync) hs_falls++;
            if (vs_prev && !vsync) vs_falls++;
            if (vblank_pulse) begin
                vb_cnt++;
                vb_at = cyc;
            end
            hs_prev = hsync;
            vs_prev = vsync;
        end
        check("f3_rgb_nonzero", nz_rgb, 32'd0);
        check("f3_hsync_falls", hs_falls, 32'd14);
        check("f3_vsync_falls", vs_falls, 32'd1);
        check("f3_vblank_cnt",  vb_cnt, 32'd1);
        check("f3_vblank_pos",  vb_at, 3 * FR + 6401);

        // Frame 4: enabled on buffer 1, then reset mid-frame
        goto(4 * FR + 4100);
        check("f4_rgb_live",   {20'd0, vga_r, vga_g, vga_b}, 32'hF00);
        check("f4_frame_buf1", {31'd0, frame_shown}, 32'd1);
        #2;
        res_n = 1'b0;
        #1;
        check("mid_rst_rgb",    {20'd0, vga_r, vga_g, vga_b}, 32'h0);
        check("mid_rst_frame",  {31'd0, frame_shown}, 32'd0);
        check("mid_rst_hsync",  {31'd0, hsync}, 32'd1);
        check("mid_rst_vsync",  {31'd0, vsync}, 32'd1);
        check("mid_rst_vblank", {31'd0, vblank_pulse}, 32'd0);
        check("mid_rst_addr",   word_addr_b, 32'd0);

        @(negedge vga_clk);
        res_n = 1'b1;
        cyc   = 0;
        goto(3);
        check("post_rst_addr",  word_addr_b, 32'd1);
        check("post_rst_frame", {31'd0, frame_shown}, 32'd0);
        goto(12);
        check("post_rst_rgb",   {20'd0, vga_r, vga_g, vga_b}, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
